// File: rtl/huff_packer_pkg.sv
// huff_packer_pkg: shared constants, FSM encoding and code-length helper for the Huffman packer.
package huff_packer_pkg;
  localparam int NSYM = 6;
  localparam int MAXLEN = 8;
  localparam int ACC_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  function automatic int mask_len(input logic [31:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m[i]);
    return n;
  endfunction
endpackage

// File: rtl/huff_code_lut.sv
// huff_code_lut: registered code table; maps a symbol to its masked code, length and illegal flag.
module huff_code_lut
  import huff_packer_pkg::*;
#(
  parameter int MAXLEN = huff_packer_pkg::MAXLEN,
  localparam int LW = $clog2(MAXLEN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_load,
  input  logic [NSYM-1:0][MAXLEN-1:0]  i_hc,
  input  logic [NSYM-1:0][MAXLEN-1:0]  i_m,
  input  logic [7:0]                   i_sym,
  output logic [MAXLEN-1:0]            o_code,
  output logic [LW-1:0]                o_len,
  output logic                         o_illegal
);
  logic [NSYM-1:0][MAXLEN-1:0] r_code;
  logic [NSYM-1:0][LW-1:0]     r_len;
  logic                        w_ok;
  logic [2:0]                  w_idx;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_code <= '0;
      r_len  <= '0;
    end else if (i_load) begin
      for (int i = 0; i < NSYM; i++) begin
        r_code[i] <= i_hc[i] & i_m[i];
        r_len[i]  <= LW'(mask_len(32'(i_m[i])));
      end
    end
  end
  always_comb begin
    w_ok      = i_sym != 8'd0 && i_sym <= 8'(NSYM);
    w_idx     = w_ok ? i_sym[2:0] - 3'd1 : 3'd0;
    o_code    = w_ok ? r_code[w_idx] : '0;
    o_len     = w_ok ? r_len[w_idx] : '0;
    o_illegal = !w_ok || o_len == '0;
  end
endmodule

// File: rtl/huff_packer.sv
// huff_packer: appends Huffman codes for a symbol stream into a left-aligned bit accumulator
// and hands the bits out MSB-first as bytes over a valid/ready interface.
module huff_packer
  import huff_packer_pkg::*;
#(
  parameter int ACC_W  = huff_packer_pkg::ACC_W,
  parameter int MAXLEN = huff_packer_pkg::MAXLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [MAXLEN-1:0] HC1,
  input  logic [MAXLEN-1:0] HC2,
  input  logic [MAXLEN-1:0] HC3,
  input  logic [MAXLEN-1:0] HC4,
  input  logic [MAXLEN-1:0] HC5,
  input  logic [MAXLEN-1:0] HC6,
  input  logic [MAXLEN-1:0] M1,
  input  logic [MAXLEN-1:0] M2,
  input  logic [MAXLEN-1:0] M3,
  input  logic [MAXLEN-1:0] M4,
  input  logic [MAXLEN-1:0] M5,
  input  logic [MAXLEN-1:0] M6,
  input  logic              sym_valid,
  input  logic [7:0]        sym_data,
  output logic              sym_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              err,
  output logic [15:0]       bit_cnt
);
  localparam int CW = $clog2(ACC_W + 1);
  localparam int LW = $clog2(MAXLEN + 1);
  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CW-1:0]     r_cnt;
  logic              w_load, w_fire, w_app, w_pop, w_ill;
  logic [MAXLEN-1:0] w_code;
  logic [LW-1:0]     w_len;
  logic [CW-1:0]     w_cnt_pop, w_sh;
  logic [ACC_W-1:0]  w_acc_pop, w_ins;
  logic [16:0]       w_bc_sum;
  assign w_load = code_valid && (r_state == S_IDLE || r_state == S_DONE);
  huff_code_lut #(.MAXLEN(MAXLEN)) u_lut (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_hc     ({HC6, HC5, HC4, HC3, HC2, HC1}),
    .i_m      ({M6, M5, M4, M3, M2, M1}),
    .i_sym    (sym_data),
    .o_code   (w_code),
    .o_len    (w_len),
    .o_illegal(w_ill)
  );
  // Leaving MAXLEN bits of headroom means any accepted code always fits.
  assign sym_ready = r_state == S_RUN && r_cnt <= CW'(ACC_W - MAXLEN);
  assign out_valid = r_cnt >= CW'(8) || (r_state == S_FLUSH && r_cnt != '0);
  assign out_data  = r_acc[ACC_W-1 -: 8];
  assign w_fire    = sym_valid && sym_ready;
  assign w_app     = w_fire && !w_ill;
  assign w_pop     = out_valid && out_ready;
  assign w_cnt_pop = w_pop ? (r_cnt >= CW'(8) ? r_cnt - CW'(8) : '0) : r_cnt;
  assign w_acc_pop = w_pop ? r_acc << 8 : r_acc;
  assign w_sh      = CW'(ACC_W) - w_cnt_pop - CW'(w_len);
  assign w_ins     = w_app ? ACC_W'(w_code) << w_sh : '0;
  assign w_bc_sum  = {1'b0, bit_cnt} + 17'(w_len);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      r_acc <= w_acc_pop | w_ins;
      r_cnt <= w_cnt_pop + (w_app ? CW'(w_len) : '0);
      done  <= 1'b0;
      if (w_fire && w_ill) err <= 1'b1;
      if (w_app) bit_cnt <= w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
      if (w_load) begin
        r_state <= S_RUN;
        err     <= 1'b0;
        bit_cnt <= '0;
      end else if (r_state == S_RUN && flush) begin
        r_state <= S_FLUSH;
      end else if (r_state == S_FLUSH && r_cnt == '0) begin
        r_state <= S_DONE;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_huff_packer.sv
// tb_huff_packer: directed and randomized checks of huff_packer against a bit-queue reference model.
module tb_huff_packer;
  typedef logic [7:0] tbl_t [6];
  logic       clk = 0, reset = 0, code_valid = 0, sym_valid = 0, flush = 0, out_ready = 0;
  tbl_t       hc = '{default: '0}, m = '{default: '0};
  logic [7:0] sym_data = 0;
  logic       sym_ready, out_valid, done, err;
  logic [7:0] out_data;
  logic [15:0] bit_cnt;
  int errors = 0, checks = 0, cyc = 0, pop_cyc = 0, done_cyc = 0, done_cnt = 0, exp_bc = 0;
  bit exp_err = 0, rnd_bp = 0;
  int t_code [1:6], t_len [1:6];
  logic [7:0] got [$];
  bit bits [$];
  tbl_t tc, tm, tx;

  huff_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(m[0]), .M2(m[1]), .M3(m[2]), .M4(m[3]), .M5(m[4]), .M6(m[5]),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (reset && out_valid && out_ready) begin
      got.push_back(out_data);
      pop_cyc = cyc;
    end
    if (reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input tbl_t c, input tbl_t ml, input bit take);
    hc = c; m = ml; code_valid = 1; tick; code_valid = 0;
    if (take) begin
      for (int i = 0; i < 6; i++) begin
        t_len[i+1]  = $countones(ml[i]);
        t_code[i+1] = int'(c[i] & ml[i]);
      end
      bits.delete(); got.delete(); exp_bc = 0; exp_err = 0;
    end
  endtask

  task automatic send(input int s);
    bit ok = 0;
    sym_data = 8'(s); sym_valid = 1;
    for (int k = 0; k < 300 && !ok; k++) begin
      ok = sym_ready;
      tick;
    end
    sym_valid = 0;
    chk("sym_accept", 32'(ok), 1);
    if (ok) begin
      if (s >= 1 && s <= 6 && t_len[s] > 0) begin
        for (int b = t_len[s] - 1; b >= 0; b--) bits.push_back(t_code[s][b]);
        exp_bc += t_len[s];
      end else exp_err = 1;
    end
  endtask

  task automatic finish_stream(input string tag);
    int d0 = done_cnt, nb;
    logic [7:0] e;
    flush = 1; tick; flush = 0;
    for (int k = 0; k < 400 && done_cnt == d0; k++) tick;
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    tick; tick; tick;
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    nb = (bits.size() + 7) / 8;
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(nb));
    for (int i = 0; i < nb && i < got.size(); i++) begin
      for (int b = 0; b < 8; b++) e[7-b] = (i*8 + b < bits.size()) ? bits[i*8 + b] : 1'b0;
      chk({tag, "_byte"}, 32'(got[i]), 32'(e));
    end
    chk({tag, "_bit_cnt"}, 32'(bit_cnt), 32'(exp_bc > 65535 ? 65535 : exp_bc));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sym_ready"}, 32'(sym_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  initial begin
    int d0;
    tc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    tm = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    tx = '{default: 8'hFF};
    tick; tick;
    chk_zero("reset");
    reset = 1;
    tick;
    chk_zero("idle");

    // basic pack
    out_ready = 1;
    load(tc, tm, 1);
    foreach (tc[i]) ;
    send(1); send(2); send(3); send(1); send(1); send(2);
    finish_stream("basic");
    chk("basic_b0", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'h58);
    chk("basic_b1", 32'(got.size() > 1 ? got[1] : 8'hxx), 32'h80);
    chk("basic_done_lat", 32'(done_cyc - pop_cyc), 2);

    // backpressure
    out_ready = 0;
    load(tc, tm, 1);
    sym_data = 6; sym_valid = 1;
    chk("bp_ready0", 32'(sym_ready), 1);
    tick;
    chk("bp_ready1", 32'(sym_ready), 1);
    tick;
    sym_valid = 0;
    for (int k = 0; k < 2; k++) begin
      for (int b = 4; b >= 0; b--) bits.push_back(1'b1);
      exp_bc += 5;
    end
    chk("bp_ready_drop", 32'(sym_ready), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 32'hFF);
    tick; tick; tick;
    chk("bp_data_stable", 32'(out_data), 32'hFF);
    chk("bp_no_pop", 32'(got.size()), 0);
    out_ready = 1;
    send(6); send(6);
    finish_stream("bp");
    chk("bp_last", 32'(got.size() == 3 ? got[2] : 8'hxx), 32'hF0);

    // simultaneous pop and append
    load(tc, tm, 1);
    send(4); send(4);
    chk("sim_valid", 32'(out_valid), 1);
    chk("sim_ready", 32'(sym_ready), 1);
    chk("sim_data", 32'(out_data), 32'hEE);
    send(4);
    chk("sim_pop_same_cycle", 32'(got.size()), 1);
    chk("sim_after", 32'(out_valid), 0);
    finish_stream("sim");

    // illegal symbols
    load(tc, tm, 1);
    send(1);
    chk("ill_err_pre", 32'(err), 0);
    send(0);
    chk("ill_err_0", 32'(err), 1);
    send(7);
    send(2);
    finish_stream("ill");
    chk("ill_byte", 32'(got.size() == 1 ? got[0] : 8'hxx), 32'h40);

    // reload clears counters; reload while running is ignored
    load(tc, tm, 1);
    chk("reload_err", 32'(err), 0);
    chk("reload_bc", 32'(bit_cnt), 0);
    send(1);
    load(tx, tx, 0);
    send(2);
    finish_stream("ignore");
    chk("ignore_byte", 32'(got.size() == 1 ? got[0] : 8'hxx), 32'h40);

    // empty flush
    load(tc, tm, 1);
    finish_stream("empty");

    // randomized tables, symbols and backpressure
    for (int r = 0; r < 20; r++) begin
      tbl_t rc, rm;
      for (int i = 0; i < 6; i++) begin
        int l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
        rm[i] = 8'((1 << l) - 1);
        rc[i] = 8'($urandom);
      end
      load(rc, rm, 1);
      rnd_bp = 1;
      for (int s = 0; s < 30; s++) send(int'($urandom_range(0, 7)));
      finish_stream("rand");
      rnd_bp = 0;
      out_ready = 1;
    end

    // reset mid-operation
    out_ready = 0;
    load(tc, tm, 1);
    send(1); send(4);
    flush = 1; tick; flush = 0;
    chk("rst_pend_valid", 32'(out_valid), 1);
    chk("rst_pend_data", 32'(out_data), 32'h70);
    d0 = done_cnt;
    reset = 0;
    tick;
    chk_zero("rst_mid");
    reset = 1;
    out_ready = 1; sym_data = 1; sym_valid = 1;
    tick; tick; tick; tick;
    chk("rst_idle_ready", 32'(sym_ready), 0);
    chk("rst_no_byte", 32'(got.size()), 0);
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    sym_valid = 0;
    load(tc, tm, 1);
    chk("rst_restart_ready", 32'(sym_ready), 1);
    send(3);
    finish_stream("restart");

    // bit_cnt saturation
    load(tx, tx, 1);
    for (int s = 0; s < 8200; s++) send(int'($urandom_range(1, 6)));
    chk("sat_bc", 32'(bit_cnt), 32'hFFFF);
    finish_stream("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/huff_packer.md
Name: huff_packer

Overview:
- Downstream stage of the Huffman encoder.
- Latches the 6-entry code table (HC1..HC6 codes, M1..M6 masks) when code_valid pulses.
- Then accepts a stream of gray symbols and emits the Huffman-coded bitstream packed MSB-first into bytes, using a valid/ready output handshake.
- An explicit flush zero-pads the final partial byte and signals completion.

Parameters:
- ACC_W, 16, bit-accumulator width; must be ≥ 2*MAXLEN.
- MAXLEN, 8, maximum code length in bits; equals the HC/M width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- code_valid  in  1  one-cycle pulse; HC1..HC6/M1..M6 valid this cycle
- HC1..HC6  in  8 each  code for symbol i, right-aligned
- M1..M6  in  8 each  mask for symbol i, contiguous ones from bit 0; code length = popcount
- sym_valid  in  1  input symbol present
- sym_data  in  8  symbol value, legal range 1..6
- sym_ready  out  1  packer accepts the symbol this cycle
- flush  in  1  one-cycle pulse: end of stream
- out_valid  out  1  out_data holds a packed byte
- out_data  out  8  packed byte; first code bit in bit 7
- out_ready  in  1  downstream takes the byte
- done  out  1  one-cycle pulse after the last byte is handed off
- err  out  1  sticky illegal-symbol / empty-mask flag
- bit_cnt  out  16  total code bits appended since table load; saturates at 0xFFFF

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; table cleared.
  - acc=0, cnt=0, sym_ready=0, out_valid=0, out_data=0, done=0, err=0, bit_cnt=0.
  - Reset mid-stream discards all buffered bits; no byte is emitted.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE: wait for code_valid.
  - IDLE→RUN on code_valid: latch all 12 table inputs; per entry, length = popcount(Mi).
  - RUN→FLUSH on flush. If flush and sym_valid arrive together, the symbol is accepted first (when sym_ready=1), then flush takes effect.
  - FLUSH→DONE once cnt==0 and no byte is pending. done pulses for exactly 1 cycle on entry to DONE.
  - DONE→RUN on code_valid (new table, bit_cnt cleared, err cleared). Otherwise stay in DONE.
  - code_valid in RUN or FLUSH is ignored.
- Accumulator:
  - acc[ACC_W-1:0] holds cnt valid bits, left-aligned at acc[ACC_W-1].
  - Append code c of length L: acc |= (c & mask) << (ACC_W-cnt-L). cnt += L.
- sym_ready = (state==RUN) && (cnt ≤ ACC_W-MAXLEN). This is a combinational function of registered state.
- Symbol handshake fires when sym_valid && sym_ready. Latency: bits appear in acc the next cycle.
- Illegal symbols (sym_data 0 or >6) and symbols whose mask is 0: the symbol is consumed, no bits are appended, and err is set (sticky).
- Output:
  - out_valid = (cnt ≥ 8), or (state==FLUSH && cnt>0).
  - out_data = acc[ACC_W-1 -: 8]; bits below cnt are already 0, so this zero-pads the final byte.
  - On out_valid && out_ready: acc <<= 8, cnt = (cnt ≥ 8) ? cnt-8 : 0.
  - out_data/out_valid stay stable while out_ready is low.
- Simultaneous pop and append in one cycle are both applied: acc = (acc<<8) | (code aligned to the post-pop count); cnt = cnt - 8 + L.
- No bits are ever lost. sym_ready guarantees room for a worst-case MAXLEN-bit code.
- bit_cnt increments by L per legal accepted symbol and saturates at 0xFFFF.
- Flush with cnt==0: no byte is emitted; done pulses the next cycle.

Decomposition:
- Shared package holds:
  - symbol count NSYM=6
  - MAXLEN, ACC_W
  - state encoding (IDLE/RUN/FLUSH/DONE)
  - popcount-to-length helper function
- One natural sub-module, huff_code_lut: registered 6-entry table. Load on code_valid; combinational lookup sym→{code, length, illegal}. The FSM and accumulator stay in huff_packer.

Test Plan:
- Table load and basic pack:
  - Table: HC1=0x00/M1=0x01, HC2=0x02/M2=0x03, HC3=0x06/M3=0x07, HC4=0x0E/M4=0x0F, HC5=0x1E/M5=0x1F, HC6=0x1F/M6=0x1F.
  - Stream 1,2,3,1,1,2, then flush, out_ready=1.
  - Expect bytes 0x58, 0x80; bit_cnt=10; done one cycle after the 0x80 handoff; err=0.
- Backpressure:
  - Same table, symbols 6×4 (20 bits), out_ready held 0.
  - sym_ready drops once cnt>8, after the second symbol (cnt=10).
  - out_data=0xFF stays stable.
  - Release out_ready → bytes 0xFF, 0xFF, 0xF0 after flush; bit_cnt=20.
- Simultaneous pop and append:
  - Symbols 4,4,4 (12 bits, "1110" ×3) with out_ready=1.
  - First byte 0xEE emitted in the same cycle the third symbol is accepted.
  - After flush, 0xE0 emitted; no bit dropped.
- Illegal symbol:
  - Inject sym_data=0 and then 7 between symbols 1 and 2.
  - Both consumed, err=1 sticky, stream bits unchanged ("010" → byte 0x40 after flush).
- Reset mid-operation:
  - Assert reset with cnt=5 and out_valid pending.
  - Next cycle: state IDLE, all outputs 0, sym_ready=0.
  - code_valid before any table reload is required to restart.
- Ignored reload / reuse:
  - code_valid during RUN does not change the codes.
  - After done, a new table via code_valid re-enters RUN with bit_cnt=0 and err=0.
  - Flush with empty accumulator gives done with zero output bytes.
